mem_access_ctrl: RTL and testbench

Memory-stage access initiator for the Y86-64 datapath. Takes the Memory-stage operands (icode, valA, valE, valP), decides whether a data-memory read or write is needed, drives a req/ack transaction to a variable-latency data memory, and returns valM with a one-cycle completion pulse. It asserts busy to stall the pipeline and raises DataMemError on out-of-range addresses or when a memory response never arrives.

---
 rtl/y86_pkg.sv | 23 ++
 rtl/mem_access_decode.sv | 44 ++++
 rtl/mem_access_ctrl.sv | 159 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes and the memory-access FSM states.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mem_access_decode.sv
// Memory-stage decode: classifies the instruction and selects address and write data.
module mem_access_decode
    import y86_pkg::*;
(
    input  logic [3:0]  icode,
    input  logic [63:0] valA,
    input  logic [63:0] valE,
    input  logic [63:0] valP,
    output logic        is_access,
    output logic        is_write,
    output logic [63:0] addr,
    output logic [63:0] wdata
);

    always_comb begin
        is_access = 1'b0;
        is_write  = 1'b0;
        addr      = valE;
        wdata     = valA;
        case (icode)
            IRMMOVQ: begin
                is_access = 1'b1;
                is_write  = 1'b1;
            end
            IMRMOVQ: is_access = 1'b1;
            ICALL: begin
                is_access = 1'b1;
                is_write  = 1'b1;
                wdata     = valP;
            end
            IPUSHQ: begin
                is_access = 1'b1;
                is_write  = 1'b1;
            end
            // Stack pops read through the old stack pointer carried in valA.
            IRET, IPOPQ: begin
                is_access = 1'b1;
                addr      = valA;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access initiator: one req/ack transaction per instruction, with
// range checking, timeout and a single-cycle completion pulse.
module mem_access_ctrl
    import y86_pkg::*;
#(
    parameter int MemSize       = 20,
    parameter int TimeoutCycles = 15
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic [63:0] valA,
    input  logic [63:0] valE,
    input  logic [63:0] valP,
    output logic        busy,
    output logic        done,
    output logic [63:0] valM,
    output logic        DataMemError,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata
);

    localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [63:0]     val_m_q, val_m_d;
    logic            err_q, err_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [63:0]     addr_q, addr_d;
    logic [63:0]     wdata_q, wdata_d;

    logic            dec_access;
    logic            dec_write;
    logic [63:0]     dec_addr;
    logic [63:0]     dec_wdata;
    logic            out_of_range;
    logic            timed_out;

    mem_access_decode u_decode (
        .icode     (icode),
        .valA      (valA),
        .valE      (valE),
        .valP      (valP),
        .is_access (dec_access),
        .is_write  (dec_write),
        .addr      (dec_addr),
        .wdata     (dec_wdata)
    );

    // Unsigned compare: negative valE wraps to a huge address and is rejected.
    assign out_of_range = dec_addr >= 64'(MemSize);
    assign timed_out    = cnt_q == CntLast;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (!dec_access || out_of_range) ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem_ack || timed_out) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        val_m_d = val_m_q;
        err_d   = err_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (!dec_access) begin
                        err_d = 1'b0;
                    end else if (out_of_range) begin
                        err_d = 1'b1;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = dec_write;
                        addr_d  = dec_addr;
                        wdata_d = dec_wdata;
                        cnt_d   = '0;
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    req_d = 1'b0;
                    err_d = 1'b0;
                    if (!we_q) begin
                        val_m_d = mem_rdata;
                    end
                end else if (timed_out) begin
                    req_d = 1'b0;
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q   <= '0;
            val_m_q <= '0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            val_m_q <= val_m_d;
            err_q   <= err_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy         = state_q != IDLE;
    assign done         = state_q == DONE;
    assign valM         = val_m_q;
    assign DataMemError = err_q;
    assign mem_req      = req_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, hand-written corner sequences
// and randomized transactions against a behavioural model.
module tb_mem_access_ctrl;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        start;
    logic [3:0]  icode;
    logic [63:0] valA, valE, valP;
    logic        busy, done, DataMemError;
    logic [63:0] valM;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    mem_access_ctrl #(.MemSize(20), .TimeoutCycles(15)) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .start        (start),
        .icode        (icode),
        .valA         (valA),
        .valE         (valE),
        .valP         (valP),
        .busy         (busy),
        .done         (done),
        .valM         (valM),
        .DataMemError (DataMemError),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [63:0] m_valm;
    logic        m_err;

    typedef struct {
        logic [3:0]  ic;
        logic [63:0] a, e, p, rd;
        int          dly;
        int          lat, reqc;
        logic        we;
        logic [63:0] addr, wdata;
        logic        err;
        logic [63:0] valm;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected outcome computed from the instruction semantics.
    task automatic model_txn(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                             input logic [63:0] p, input logic [63:0] rd, input int dly,
                             output int lat, output int reqc, output logic we,
                             output logic [63:0] addr, output logic [63:0] wdata);
        logic acc;
        acc = 1'b1; we = 1'b0; addr = e; wdata = a;
        case (ic)
            4'h4: we = 1'b1;
            4'h5: ;
            4'h8: begin we = 1'b1; wdata = p; end
            4'h9: addr = a;
            4'hA: we = 1'b1;
            4'hB: addr = a;
            default: acc = 1'b0;
        endcase
        if (!acc) begin
            m_err = 1'b0; lat = 1; reqc = 0;
        end else if (addr >= 64'd20) begin
            m_err = 1'b1; lat = 1; reqc = 0;
        end else if (dly >= 15) begin
            m_err = 1'b1; lat = 16; reqc = 15;
        end else begin
            m_err = 1'b0; lat = dly + 2; reqc = dly + 1;
            if (!we) m_valm = rd;
        end
    endtask

    // Starts at a falling edge with the DUT idle; returns at a falling edge, idle again.
    task automatic run_txn(input string tag, input logic [3:0] ic, input logic [63:0] a,
                           input logic [63:0] e, input logic [63:0] p, input logic [63:0] rd,
                           input int dly, input bit abuse, input int exp_lat, input int exp_reqc,
                           input logic exp_we, input logic [63:0] exp_addr,
                           input logic [63:0] exp_wdata, input logic exp_err,
                           input logic [63:0] exp_valm);
        int  cyc;
        int  reqc;
        int  extra;
        bit  stable;
        bit  got_done;
        start = 1'b1; icode = ic; valA = a; valE = e; valP = p;
        @(negedge Clk);
        start = 1'b0;
        if (abuse) begin
            start = 1'b1;
            icode = 4'h6;
        end
        cyc = 1; reqc = 0; stable = 1'b1; got_done = 1'b0;
        while (cyc <= 40) begin
            mem_ack = 1'b0;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (cyc == 2) start = 1'b0;
            if (mem_req) begin
                reqc++;
                if (mem_we !== exp_we || mem_addr !== exp_addr ||
                    (exp_we && mem_wdata !== exp_wdata)) stable = 1'b0;
                mem_ack   = (reqc - 1 == dly);
                mem_rdata = mem_ack ? rd : {$urandom, $urandom};
            end
            @(negedge Clk);
            cyc++;
        end
        mem_ack = 1'b0;
        start   = 1'b0;
        chk({tag, "_done_seen"}, 64'(got_done), 64'd1);
        chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, "_req_cycles"}, 64'(reqc), 64'(exp_reqc));
        if (exp_reqc > 0) chk({tag, "_req_fields"}, 64'(stable), 64'd1);
        chk({tag, "_err"}, 64'(DataMemError), 64'(exp_err));
        chk({tag, "_valM"}, valM, exp_valm);
        chk({tag, "_busy_in_done"}, 64'(busy), 64'd1);
        @(negedge Clk);
        chk({tag, "_done_one_cycle"}, 64'(done), 64'd0);
        chk({tag, "_idle_after"}, 64'(busy | mem_req), 64'd0);
        if (abuse) begin
            extra = 0;
            for (int i = 0; i < 5; i++) begin
                if (done || mem_req || busy) extra++;
                @(negedge Clk);
            end
            chk({tag, "_no_extra_txn"}, 64'(extra), 64'd0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, reqc;
        logic        we;
        logic [63:0] addr, wdata;
        logic [3:0]  ic;
        logic [63:0] a, e, p, rd;
        int          dly;
        int          bad;

        //         ic     a        e        p          rd         dly lat req we addr   wdata      err valm
        vecs[0] = '{4'h4, 64'd42, 64'd3,  64'd0,     64'd0,     2,  4,  3,  1, 64'd3,  64'd42,    0, 64'd0};
        vecs[1] = '{4'h5, 64'd0,  64'd7,  64'd0,     64'd99,    0,  2,  1,  0, 64'd7,  64'd0,     0, 64'd99};
        vecs[2] = '{4'hB, 64'd7,  64'd0,  64'd0,     64'd5,     0,  2,  1,  0, 64'd7,  64'd0,     0, 64'd5};
        vecs[3] = '{4'hA, 64'd1,  64'd20, 64'd0,     64'd0,     0,  1,  0,  1, 64'd20, 64'd1,     1, 64'd5};
        vecs[4] = '{4'h8, 64'd1,  -64'sd8,64'd0,     64'd0,     0,  1,  0,  1, 64'd0,  64'd0,     1, 64'd5};
        vecs[5] = '{4'h6, 64'd1,  64'd2,  64'd0,     64'd0,     0,  1,  0,  0, 64'd0,  64'd0,     0, 64'd5};
        vecs[6] = '{4'h9, 64'd2,  64'd0,  64'd0,     64'd77,    20, 16, 15, 0, 64'd2,  64'd0,     1, 64'd5};
        vecs[7] = '{4'h8, 64'd3,  64'd19, 64'h1234,  64'd0,     1,  3,  2,  1, 64'd19, 64'h1234,  0, 64'd5};
        vecs[8] = '{4'hB, 64'd19, 64'd0,  64'd0,     64'hdead,  3,  5,  4,  0, 64'd19, 64'd0,     0, 64'hdead};

        Rst_n = 1'b0; start = 1'b0; icode = '0; valA = '0; valE = '0; valP = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge Clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_req", 64'(mem_req), 64'd0);
        chk("reset_we", 64'(mem_we), 64'd0);
        chk("reset_err", 64'(DataMemError), 64'd0);
        chk("reset_valM", valM, 64'd0);
        chk("reset_addr", mem_addr, 64'd0);
        chk("reset_wdata", mem_wdata, 64'd0);
        Rst_n = 1'b1;
        @(negedge Clk);

        for (int i = 0; i < 9; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].ic, vecs[i].a, vecs[i].e, vecs[i].p,
                    vecs[i].rd, vecs[i].dly, 1'b0, vecs[i].lat, vecs[i].reqc, vecs[i].we,
                    vecs[i].addr, vecs[i].wdata, vecs[i].err, vecs[i].valm);
        end
        m_valm = 64'hdead;
        m_err  = 1'b0;

        // start pulsed while busy must be ignored
        model_txn(4'h5, 64'd0, 64'd4, 64'd0, 64'h77, 1, lat, reqc, we, addr, wdata);
        run_txn("abuse_start", 4'h5, 64'd0, 64'd4, 64'd0, 64'h77, 1, 1'b1, lat, reqc, we,
                addr, wdata, m_err, m_valm);

        // mem_ack while idle must be ignored
        bad = 0;
        mem_ack = 1'b1; mem_rdata = 64'h5555;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            if (done || busy || mem_req) bad++;
        end
        mem_ack = 1'b0;
        chk("idle_ack_no_activity", 64'(bad), 64'd0);
        chk("idle_ack_valM", valM, m_valm);

        // Reset in the middle of a request
        start = 1'b1; icode = 4'h5; valE = 64'd2;
        @(negedge Clk);
        start = 1'b0;
        repeat (2) @(negedge Clk);
        chk("midreq_req_before", 64'(mem_req), 64'd1);
        #2 Rst_n = 1'b0;
        #1;
        chk("midreq_req_dropped", 64'(mem_req), 64'd0);
        chk("midreq_busy_dropped", 64'(busy), 64'd0);
        bad = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            if (done) bad++;
        end
        Rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            if (done || busy || mem_req) bad++;
        end
        chk("midreq_no_done", 64'(bad), 64'd0);
        chk("midreq_valM", valM, 64'd0);
        chk("midreq_err", 64'(DataMemError), 64'd0);
        chk("midreq_addr", mem_addr, 64'd0);
        chk("midreq_wdata", mem_wdata, 64'd0);
        chk("midreq_we", 64'(mem_we), 64'd0);
        m_valm = 64'd0;
        m_err  = 1'b0;

        for (int n = 0; n < 40; n++) begin
            ic = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 24));
            e  = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 24));
            p  = {$urandom, $urandom};
            rd = {$urandom, $urandom};
            dly = $urandom_range(0, 16);
            model_txn(ic, a, e, p, rd, dly, lat, reqc, we, addr, wdata);
            run_txn($sformatf("rnd%0d_ic%0h", n, ic), ic, a, e, p, rd, dly, 1'b0, lat, reqc,
                    we, addr, wdata, m_err, m_valm);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
